// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Brief    : Pipeline hazard controller: load/link-use stall, redirect squash
//            and registered EX-stage bypass selects for the ALU.
// Revision : 1.0
// ============================================================================
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwen,
    input  logic [1:0]       id_wbsel,
    input  logic             ex_redirect,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [CNT_W-1:0] load_use_count
);

    localparam logic [1:0] c_WB_ALU  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_RF  = 2'b00;

    // The regfile is write-before-read, so the WB shadow never affects any
    // output; only the EX and MEM shadows are held.
    logic       r_ex_valid, r_ex_regwen;
    logic [4:0] r_ex_rd;
    logic [1:0] r_ex_wbsel;
    logic       r_mem_valid, r_mem_regwen;
    logic [4:0] r_mem_rd;

    logic       w_ex_live, w_mem_live, w_ex_is_alu;
    logic       w_hazard, w_load_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    function automatic logic [1:0] sel_for(input logic use_src, input logic [4:0] rs,
                                           input logic ex_live, input logic [4:0] ex_rd,
                                           input logic ex_alu, input logic mem_live,
                                           input logic [4:0] mem_rd);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (use_src && rs != 5'd0) begin
            if (ex_live && ex_rd == rs && ex_alu)
                sel = c_FWD_MEM;
            else if (mem_live && mem_rd == rs)
                sel = c_FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        w_ex_live   = r_ex_valid & r_ex_regwen & (r_ex_rd != 5'd0);
        w_mem_live  = r_mem_valid & r_mem_regwen & (r_mem_rd != 5'd0);
        w_ex_is_alu = (r_ex_wbsel == c_WB_ALU);
        // Loads and links only become bypassable once they reach WB.
        w_hazard    = id_valid & w_ex_live & ~w_ex_is_alu & ~ex_redirect &
                      ((id_use_rs1 & (id_rs1 == r_ex_rd)) |
                       (id_use_rs2 & (id_rs2 == r_ex_rd)));
        stall_if      = w_hazard;
        bubble_ex     = w_hazard | ex_redirect;
        flush_id      = ex_redirect;
        w_load_bubble = bubble_ex | ~id_valid;
        w_fwd_a = sel_for(id_use_rs1, id_rs1, w_ex_live, r_ex_rd, w_ex_is_alu,
                          w_mem_live, r_mem_rd);
        w_fwd_b = sel_for(id_use_rs2, id_rs2, w_ex_live, r_ex_rd, w_ex_is_alu,
                          w_mem_live, r_mem_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_regwen    <= 1'b0;
            r_ex_rd        <= 5'd0;
            r_ex_wbsel     <= 2'b00;
            r_mem_valid    <= 1'b0;
            r_mem_regwen   <= 1'b0;
            r_mem_rd       <= 5'd0;
            forwardA       <= c_FWD_RF;
            forwardB       <= c_FWD_RF;
            load_use_count <= '0;
        end else begin
            r_mem_valid  <= r_ex_valid;
            r_mem_regwen <= r_ex_regwen;
            r_mem_rd     <= r_ex_rd;
            r_ex_valid   <= ~w_load_bubble;
            r_ex_regwen  <= id_regwen;
            r_ex_rd      <= id_rd;
            r_ex_wbsel   <= id_wbsel;
            forwardA     <= w_load_bubble ? c_FWD_RF : w_fwd_a;
            forwardB     <= w_load_bubble ? c_FWD_RF : w_fwd_b;
            if (w_hazard && load_use_count != {CNT_W{1'b1}})
                load_use_count <= load_use_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Brief    : Directed plus random self-checking bench for hazard_unit against
//            an instruction-level pipeline model.
// Revision : 1.0
// ============================================================================
module tb_hazard_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_regwen, ex_redirect;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic [1:0]    id_wbsel;
    logic [1:0]    forwardA, forwardB;
    logic          stall_if, bubble_ex, flush_id;
    logic [CW-1:0] load_use_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_wbsel(id_wbsel),
        .ex_redirect(ex_redirect),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .load_use_count(load_use_count)
    );

    // Model: the instruction occupying each later stage, youngest first.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wen;
        bit [1:0] wb;
    } ins_t;

    ins_t          older [2];   // [0] = in EX, [1] = in MEM
    logic [1:0]    m_fa, m_fb;
    logic [CW-1:0] m_cnt;

    function automatic bit produces(input ins_t p, input bit [4:0] r);
        return p.v && p.wen && p.rd == r && r != 5'd0;
    endfunction

    function automatic logic [1:0] model_sel(input bit u, input bit [4:0] rs);
        if (!u) return 2'b00;
        if (produces(older[0], rs) && older[0].wb == 2'b01) return 2'b10;
        if (produces(older[1], rs)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ex_redirect = 1'b0;
        @(posedge clk);
        #1;
        older[0] = '{0, 0, 0, 0};
        older[1] = '{0, 0, 0, 0};
        m_fa = 2'b00; m_fb = 2'b00; m_cnt = '0;
        check("rst_fa",  {6'd0, forwardA}, 8'h0);
        check("rst_fb",  {6'd0, forwardB}, 8'h0);
        check("rst_cnt", {{(8-CW){1'b0}}, load_use_count}, 8'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One pipeline cycle: drive ID, check combinational outputs, clock, check selects.
    task automatic cyc(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                       input bit u2, input bit [4:0] rd, input bit wen, input bit [1:0] wb,
                       input bit redir);
        bit   haz, bub;
        ins_t nxt;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwen = wen; id_wbsel = wb; ex_redirect = redir;
        #1;
        haz = v && !redir && older[0].wb != 2'b01 &&
              ((u1 && produces(older[0], rs1)) || (u2 && produces(older[0], rs2)));
        bub = haz || redir;
        check("stall_if",  {7'd0, stall_if},  {7'd0, haz});
        check("bubble_ex", {7'd0, bubble_ex}, {7'd0, bub});
        check("flush_id",  {7'd0, flush_id},  {7'd0, redir});
        if (bub || !v) begin
            m_fa = 2'b00; m_fb = 2'b00;
            nxt = '{0, rd, wen, wb};
        end else begin
            m_fa = model_sel(u1, rs1);
            m_fb = model_sel(u2, rs2);
            nxt = '{1, rd, wen, wb};
        end
        if (haz && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        @(posedge clk);
        #1;
        older[1] = older[0];
        older[0] = nxt;
        check("forwardA", {6'd0, forwardA}, {6'd0, m_fa});
        check("forwardB", {6'd0, forwardB}, {6'd0, m_fb});
        check("count",    {{(8-CW){1'b0}}, load_use_count}, {{(8-CW){1'b0}}, m_cnt});
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwen = 0; id_wbsel = 0; ex_redirect = 0;
        do_reset();
        check("rst_stall", {7'd0, stall_if}, 8'h0);

        // ALU -> ALU, distance 1
        cyc(1, 1, 1, 2, 1, 5, 1, 2'b01, 0);
        cyc(1, 5, 1, 6, 1, 8, 1, 2'b01, 0);
        check("alu_fa", {6'd0, forwardA}, 8'h2);
        check("alu_fb", {6'd0, forwardB}, 8'h0);

        // Distance 2 on rs2
        cyc(1, 1, 1, 2, 1, 5, 1, 2'b01, 0);
        cyc(1, 3, 1, 4, 1, 9, 1, 2'b01, 0);
        cyc(1, 6, 1, 5, 1, 10, 1, 2'b01, 0);
        check("d2_fb", {6'd0, forwardB}, 8'h1);

        // Younger producer wins
        cyc(1, 1, 1, 2, 1, 5, 1, 2'b01, 0);
        cyc(1, 1, 1, 2, 1, 5, 1, 2'b01, 0);
        cyc(1, 5, 1, 0, 0, 11, 1, 2'b01, 0);
        check("young_fa", {6'd0, forwardA}, 8'h2);

        // Load-use: one stall, then WB bypass on both sources
        do_reset();
        cyc(1, 1, 1, 0, 0, 7, 1, 2'b00, 0);
        cyc(1, 7, 1, 7, 1, 12, 1, 2'b01, 0);
        check("lu_cnt", {{(8-CW){1'b0}}, load_use_count}, 8'h1);
        cyc(1, 7, 1, 7, 1, 12, 1, 2'b01, 0);
        check("lu_stall_gone", {7'd0, stall_if}, 8'h0);
        check("lu_fa", {6'd0, forwardA}, 8'h1);
        check("lu_fb", {6'd0, forwardB}, 8'h1);

        // Link-use
        cyc(1, 0, 0, 0, 0, 1, 1, 2'b10, 0);
        cyc(1, 1, 1, 3, 1, 13, 1, 2'b01, 0);
        cyc(1, 1, 1, 3, 1, 13, 1, 2'b01, 0);
        check("link_fa", {6'd0, forwardA}, 8'h1);

        // Redirect beats a load-use hazard
        cyc(1, 1, 1, 0, 0, 7, 1, 2'b00, 0);
        cyc(1, 7, 1, 0, 0, 14, 1, 2'b01, 1);

        // x0 producer and x0 source
        cyc(1, 1, 1, 2, 1, 0, 1, 2'b01, 0);
        cyc(1, 0, 1, 0, 1, 15, 1, 2'b01, 0);
        check("x0_fa", {6'd0, forwardA}, 8'h0);

        // Reset mid-stall
        cyc(1, 1, 1, 0, 0, 7, 1, 2'b00, 0);
        cyc(1, 7, 1, 0, 0, 16, 1, 2'b01, 0);
        do_reset();
        cyc(1, 7, 1, 0, 0, 16, 1, 2'b01, 0);

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 1, 0, 0, 7, 1, 2'b00, 0);
            cyc(1, 7, 1, 7, 1, 17, 1, 2'b01, 0);
        end
        check("sat_cnt", {{(8-CW){1'b0}}, load_use_count}, 8'hF);

        // Random traffic over a small register set to provoke collisions
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit [1:0] wbr;
            wbr = 2'($urandom_range(0, 2));
            cyc(bit'($urandom_range(0, 7) != 0),
                5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
                wbr, bit'($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
